// File: rtl/comb_calc.sv
// Signed W-bit add/sub/reverse-sub/abs calculator with a registered result and overflow flag.
// Optional macro COMB_CALC_SAT_EN: clamp R on overflow instead of wrapping.
module comb_calc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   OP,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         in_valid,
  output logic [W-1:0] R,
  output logic         ovf,
  output logic         out_valid
);

  typedef enum logic [1:0] {M_ADD, M_SUB, M_ABS} mode_t;

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  mode_t        mode;
  logic [W-1:0] x, y, raw, nxt_r;
  logic         nxt_ovf;

  // Reduce the opcode to a mode plus ordered operands; abs always works on x.
  // Unknown/unmatched opcodes fall through to A+B.
  always_comb begin
    mode = M_ADD;
    x    = A;
    y    = B;
    case (OP)
      3'b001:         mode = M_SUB;
      3'b010, 3'b011: begin mode = M_ABS; x = B; end
      3'b100:         begin x = B; y = A; end
      3'b101:         begin mode = M_SUB; x = B; y = A; end
      3'b110, 3'b111: mode = M_ABS;
      default: ;
    endcase
  end

  always_comb begin
    raw     = x + y;
    nxt_ovf = (x[W-1] == y[W-1]) && (raw[W-1] != x[W-1]);
    case (mode)
      M_SUB: begin
        raw     = x - y;
        nxt_ovf = (x[W-1] != y[W-1]) && (raw[W-1] != x[W-1]);
      end
      M_ABS: begin
        raw     = x[W-1] ? (~x + 1'b1) : x;
        nxt_ovf = (x == SMIN);
      end
      default: ;
    endcase
  end

`ifdef COMB_CALC_SAT_EN
  // On add/sub overflow the true result has the sign of x; abs overflow is always positive.
  always_comb begin
    nxt_r = raw;
    if (nxt_ovf)
      nxt_r = ((mode == M_ABS) || !x[W-1]) ? SMAX : SMIN;
  end
`else
  always_comb nxt_r = raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        R   <= nxt_r;
        ovf <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_comb_calc.sv
// Bench for comb_calc: directed plan checks plus randomized ops against a wide-integer reference model.
module tb_comb_calc;
  localparam int W = 16;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   OP;
  logic [W-1:0] A, B;
  logic         in_valid;
  logic [W-1:0] R;
  logic         ovf, out_valid;

  int total  = 0;
  int passes = 0;

  comb_calc #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .A(A), .B(B), .in_valid(in_valid),
    .R(R), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: exact math in a 64-bit integer, then wrap or clamp into W bits.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ov);
    longint sa, sb, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1:       v = sa - sb;
      3'd2, 3'd3: v = (sb < 0) ? -sb : sb;
      3'd4:       v = sb + sa;
      3'd5:       v = sb - sa;
      3'd6, 3'd7: v = (sa < 0) ? -sa : sa;
      default:    v = sa + sb;
    endcase
    ov = (v > MAXV) || (v < MINV);
`ifdef COMB_CALC_SAT_EN
    if (v > MAXV) v = MAXV;
    if (v < MINV) v = MINV;
`endif
    r = v[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // Called at a negedge: present one op, check it at the next negedge, leave in_valid low.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic eo);
    OP = op; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".R"}, R, er);
    chk1({tag, ".ovf"}, ovf, eo);
    chk1({tag, ".vld"}, out_valid, 1'b1);
  endtask

  initial begin
    logic [W-1:0] er, lr, ra, rb;
    logic         eo, lo, v;
    logic [2:0]   rop;
    logic [31:0]  rnd;

    rst_n = 1'b0; in_valid = 1'b0; OP = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst.R", R, '0);
    chk1("rst.ovf", ovf, 1'b0);
    chk1("rst.vld", out_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("idle.vld", out_valid, 1'b0);

    do_op("add",  3'b000, 16'sd10,  16'sd5,   16'sd15,  1'b0);
    do_op("sub",  3'b001, -16'sd10, -16'sd25, 16'sd15,  1'b0);
    do_op("absb", 3'b010, 16'sd7,   -16'sd100, 16'sd100, 1'b0);
    do_op("absa+", 3'b111, 16'sd30, 16'sd9,   16'sd30,  1'b0);
    do_op("absa-", 3'b110, -16'sd45, 16'sd0,  16'sd45,  1'b0);
    do_op("rsub", 3'b101, -16'sd50, 16'sd20,  16'sd70,  1'b0);
    do_op("radd", 3'b100, -16'sd40, 16'sd100, 16'sd60,  1'b0);
`ifdef COMB_CALC_SAT_EN
    do_op("ovadd", 3'b000, 16'sd32760, 16'sd100, 16'sd32767, 1'b1);
    do_op("ovsub", 3'b001, -16'sd32760, 16'sd100, 16'h8000, 1'b1);
    do_op("ovabs", 3'b110, 16'h8000, 16'sd0, 16'sd32767, 1'b1);
`else
    do_op("ovadd", 3'b000, 16'sd32760, 16'sd100, -16'sd32676, 1'b1);
    do_op("ovsub", 3'b001, -16'sd32760, 16'sd100, 16'sd32676, 1'b1);
    do_op("ovabs", 3'b110, 16'h8000, 16'sd0, 16'h8000, 1'b1);
`endif
    do_op("opx", 3'bxxx, 16'sd3, 16'sd4, 16'sd7, 1'b0);

    // Three back-to-back ops, then idle: valid for exactly three cycles, R holds.
    do_op("b2b0", 3'b000, 16'sd1, 16'sd2, 16'sd3, 1'b0);
    do_op("b2b1", 3'b001, 16'sd9, 16'sd4, 16'sd5, 1'b0);
    do_op("b2b2", 3'b100, 16'sd6, 16'sd6, 16'sd12, 1'b0);
    A = 16'sd999; B = 16'sd1;
    @(negedge clk);
    chk1("drop.vld", out_valid, 1'b0);
    chk("drop.R", R, 16'sd12);
    A = -16'sd77;
    @(negedge clk);
    chk("hold.R", R, 16'sd12);
    chk1("hold.vld", out_valid, 1'b0);

    // Async reset between edges while a result is valid.
    do_op("pre", 3'b000, 16'sd100, 16'sd23, 16'sd123, 1'b0);
    OP = 3'b000; A = 16'sd1; B = 16'sd1; in_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.R", R, '0);
    chk1("arst.ovf", ovf, 1'b0);
    chk1("arst.vld", out_valid, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rel.vld", out_valid, 1'b0);
    chk("rel.R", R, '0);

    // Randomized ops with corner operands and gaps in in_valid.
    lr = '0; lo = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rnd = $urandom;
      rop = rnd[2:0];
      v   = (rnd[4:3] != 2'b00);
      case (rnd[7:5])
        3'd0: ra = 16'h8000;
        3'd1: ra = 16'h7fff;
        3'd2: ra = 16'hffff;
        default: begin rnd = $urandom; ra = rnd[W-1:0]; end
      endcase
      rnd = $urandom;
      case (rnd[18:16])
        3'd0: rb = 16'h8000;
        3'd1: rb = 16'h7fff;
        3'd2: rb = '0;
        default: rb = rnd[W-1:0];
      endcase
      OP = rop; A = ra; B = rb; in_valid = v;
      if (v) begin
        model(rop, ra, rb, er, eo);
        lr = er; lo = eo;
      end
      @(negedge clk);
      chk("rnd.R", R, lr);
      chk1("rnd.ovf", ovf, lo);
      chk1("rnd.vld", out_valid, v);
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
